// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg: ALU control codes and widths shared by the ID/EX stage and the ALU.
package id_ex_operand_stage_pkg;
   localparam int N_W   = 32;
   localparam int CTR_W = 4;
   localparam int RSEL  = 5;
   localparam logic [CTR_W-1:0] ALU_ADD  = 4'd0;
   localparam logic [CTR_W-1:0] ALU_ADDU = 4'd1;
   localparam logic [CTR_W-1:0] ALU_SUB  = 4'd2;
   localparam logic [CTR_W-1:0] ALU_SUBU = 4'd3;
   localparam logic [CTR_W-1:0] ALU_SLT  = 4'd4;
   localparam logic [CTR_W-1:0] ALU_SLTU = 4'd5;
   localparam logic [CTR_W-1:0] ALU_SLL  = 4'd6;
   localparam logic [CTR_W-1:0] ALU_SRL  = 4'd7;
   localparam logic [CTR_W-1:0] ALU_SRA  = 4'd8;
   localparam logic [CTR_W-1:0] ALU_OR   = 4'd9;
   localparam logic [CTR_W-1:0] ALU_AND  = 4'd10;
   localparam logic [CTR_W-1:0] ALU_XOR  = 4'd11;
   localparam logic [CTR_W-1:0] ALU_NOP  = 4'd15;

   function automatic logic is_shift(input logic [CTR_W-1:0] ctr);
      return ctr == ALU_SLL || ctr == ALU_SRL || ctr == ALU_SRA;
   endfunction
endpackage

// File: rtl/id_ex_operand_stage_fwd_mux.sv
// id_ex_operand_stage_fwd_mux: picks EX/MEM, then MEM/WB, then the captured value for one source index.
module id_ex_operand_stage_fwd_mux
   import id_ex_operand_stage_pkg::*;
#(
   parameter int n    = N_W,
   parameter int Rsel = RSEL
) (
   input  logic [Rsel-1:0] idx_i,
   input  logic [n-1:0]    reg_data_i,
   input  logic            exmem_wen_i,
   input  logic [Rsel-1:0] exmem_dst_i,
   input  logic [n-1:0]    exmem_data_i,
   input  logic            memwb_wen_i,
   input  logic [Rsel-1:0] memwb_dst_i,
   input  logic [n-1:0]    memwb_data_i,
   output logic [n-1:0]    data_o
);
   logic nz;
   assign nz = idx_i != '0;
   assign data_o = (nz && exmem_wen_i && exmem_dst_i == idx_i) ? exmem_data_i :
                   (nz && memwb_wen_i && memwb_dst_i == idx_i) ? memwb_data_i : reg_data_i;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register feeding the ALU, with operand forwarding and load-use bubbles.
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int n        = N_W,
   parameter int Ctr_size = CTR_W,
   parameter int Rsel     = RSEL
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_valid,
   input  logic [n-1:0]        id_rs_data,
   input  logic [n-1:0]        id_rt_data,
   input  logic [Rsel-1:0]     id_rs,
   input  logic [Rsel-1:0]     id_rt,
   input  logic [Rsel-1:0]     id_rd,
   input  logic [n-1:0]        id_imm,
   input  logic [Ctr_size-1:0] id_alu_ctr,
   input  logic                id_use_imm,
   input  logic                id_reg_write,
   input  logic                id_mem_read,
   input  logic                id_mem_write,
   input  logic                flush,
   input  logic                ex_hold,
   input  logic                exmem_wen,
   input  logic [Rsel-1:0]     exmem_dst,
   input  logic [n-1:0]        exmem_data,
   input  logic                memwb_wen,
   input  logic [Rsel-1:0]     memwb_dst,
   input  logic [n-1:0]        memwb_data,
   output logic [n-1:0]        ADin,
   output logic [n-1:0]        BDin,
   output logic [Ctr_size-1:0] ALU_ctr,
   output logic                Carry_in,
   output logic                ex_valid,
   output logic [Rsel-1:0]     ex_dst,
   output logic                ex_reg_write,
   output logic                ex_mem_read,
   output logic                ex_mem_write,
   output logic [n-1:0]        ex_store_data,
   output logic                id_stall
);
   logic                valid_q, reg_write_q, mem_read_q, mem_write_q, use_imm_q;
   logic [Rsel-1:0]     rs_q, rt_q, dst_q;
   logic [n-1:0]        rs_data_q, rt_data_q, imm_q, fwd_rs, fwd_rt;
   logic [Ctr_size-1:0] ctr_q;
   logic                hz, bub;

   assign hz = valid_q && mem_read_q && id_valid && dst_q != '0 && (dst_q == id_rs || dst_q == id_rt);
   assign bub = flush || hz || !id_valid;
   assign id_stall = !reset && (hz || ex_hold);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= 1'b0;
         reg_write_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         use_imm_q   <= 1'b0;
         ctr_q       <= ALU_NOP;
         rs_q        <= '0;
         rt_q        <= '0;
         dst_q       <= '0;
         rs_data_q   <= '0;
         rt_data_q   <= '0;
         imm_q       <= '0;
      end else if (flush || !ex_hold) begin
         valid_q     <= !bub;
         reg_write_q <= !bub && id_reg_write;
         mem_read_q  <= !bub && id_mem_read;
         mem_write_q <= !bub && id_mem_write;
         ctr_q       <= bub ? ALU_NOP : id_alu_ctr;
         // Squashed slots leave the operand fields alone; only control is cleared.
         if (!flush && !hz) begin
            use_imm_q <= id_use_imm;
            rs_q      <= id_rs;
            rt_q      <= id_rt;
            dst_q     <= id_rd;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
         end
      end
   end

   id_ex_operand_stage_fwd_mux #(.n(n), .Rsel(Rsel)) u_fwd_rs (
      .idx_i(rs_q), .reg_data_i(rs_data_q),
      .exmem_wen_i(exmem_wen), .exmem_dst_i(exmem_dst), .exmem_data_i(exmem_data),
      .memwb_wen_i(memwb_wen), .memwb_dst_i(memwb_dst), .memwb_data_i(memwb_data),
      .data_o(fwd_rs)
   );

   id_ex_operand_stage_fwd_mux #(.n(n), .Rsel(Rsel)) u_fwd_rt (
      .idx_i(rt_q), .reg_data_i(rt_data_q),
      .exmem_wen_i(exmem_wen), .exmem_dst_i(exmem_dst), .exmem_data_i(exmem_data),
      .memwb_wen_i(memwb_wen), .memwb_dst_i(memwb_dst), .memwb_data_i(memwb_data),
      .data_o(fwd_rt)
   );

   // Shifts take the value from rt and the shift amount from BDin[10:6].
   assign ADin          = is_shift(ctr_q) ? fwd_rt : fwd_rs;
   assign BDin          = (is_shift(ctr_q) || use_imm_q) ? imm_q : fwd_rt;
   assign ALU_ctr       = ctr_q;
   assign Carry_in      = 1'b0;
   assign ex_valid      = valid_q;
   assign ex_dst        = dst_q;
   assign ex_reg_write  = reg_write_q;
   assign ex_mem_read   = mem_read_q;
   assign ex_mem_write  = mem_write_q;
   assign ex_store_data = fwd_rt;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vectors with hand-computed expectations for the ID/EX stage.
module tb_id_ex_operand_stage;
   import id_ex_operand_stage_pkg::*;
   logic        clk = 1'b0, reset;
   logic        id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
   logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_data, memwb_data;
   logic [4:0]  id_rs, id_rt, id_rd, exmem_dst, memwb_dst, ex_dst;
   logic [3:0]  id_alu_ctr, ALU_ctr;
   logic        flush, ex_hold, exmem_wen, memwb_wen;
   logic [31:0] ADin, BDin, ex_store_data;
   logic        Carry_in, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, id_stall;
   int          n_checks = 0, n_fail = 0;

   always #5 clk = ~clk;

   id_ex_operand_stage dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm), .id_alu_ctr(id_alu_ctr),
      .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .flush(flush), .ex_hold(ex_hold), .exmem_wen(exmem_wen),
      .exmem_dst(exmem_dst), .exmem_data(exmem_data), .memwb_wen(memwb_wen), .memwb_dst(memwb_dst),
      .memwb_data(memwb_data), .ADin(ADin), .BDin(BDin), .ALU_ctr(ALU_ctr), .Carry_in(Carry_in),
      .ex_valid(ex_valid), .ex_dst(ex_dst), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_store_data(ex_store_data), .id_stall(id_stall)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, imm,
                        input logic [3:0] ctr, input logic ui, rw, mr);
      id_valid = 1'b1; id_rs = rs; id_rt = rt; id_rd = rd; id_rs_data = rsd; id_rt_data = rtd;
      id_imm = imm; id_alu_ctr = ctr; id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
      id_mem_write = 1'b0;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; ex_hold = 1'b0;
      instr(0, 0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0); id_valid = 1'b0;
      exmem_wen = 1'b0; exmem_dst = 0; exmem_data = 0;
      memwb_wen = 1'b0; memwb_dst = 0; memwb_data = 0;
      step(); step();
      check("rst_valid", ex_valid, 0);
      check("rst_ctr", ALU_ctr, ALU_NOP);
      check("rst_adin", ADin, 0);
      check("rst_stall", id_stall, 0);
      check("rst_carry", Carry_in, 0);

      @(negedge clk) reset = 1'b0;
      instr(1, 2, 3, 7, 5, 0, ALU_ADD, 0, 1, 0);
      step();
      check("add_adin", ADin, 7);
      check("add_bdin", BDin, 5);
      check("add_ctr", ALU_ctr, ALU_ADD);
      check("add_valid", ex_valid, 1);
      check("add_rw", ex_reg_write, 1);
      check("add_dst", ex_dst, 3);
      check("add_carry", Carry_in, 0);

      @(negedge clk) instr(3, 3, 4, 32'h11, 32'h22, 0, ALU_ADD, 0, 1, 0);
      exmem_wen = 1'b1; exmem_dst = 3; exmem_data = 32'hAA;
      memwb_wen = 1'b1; memwb_dst = 3; memwb_data = 32'hBB;
      step();
      check("fwd_exmem_a", ADin, 32'hAA);
      check("fwd_exmem_b", BDin, 32'hAA);
      check("fwd_store", ex_store_data, 32'hAA);
      exmem_wen = 1'b0; #1;
      check("fwd_memwb_a", ADin, 32'hBB);
      check("fwd_memwb_b", BDin, 32'hBB);
      @(negedge clk) instr(0, 0, 4, 32'h11, 32'h22, 0, ALU_ADD, 0, 1, 0);
      exmem_wen = 1'b1; exmem_dst = 0; memwb_dst = 0;
      step();
      check("fwd_zero_a", ADin, 32'h11);
      check("fwd_zero_b", BDin, 32'h22);
      @(negedge clk) instr(1, 2, 4, 9, 5, 32'h40, ALU_ADD, 1, 1, 0);
      exmem_wen = 1'b0; memwb_wen = 1'b0;
      step();
      check("imm_b", BDin, 32'h40);
      check("imm_store", ex_store_data, 5);

      @(negedge clk) instr(1, 8, 8, 0, 0, 0, ALU_ADD, 1, 1, 1);
      step();
      check("lw_in_ex", ex_mem_read, 1);
      @(negedge clk) instr(8, 9, 10, 32'hDEAD, 2, 0, ALU_ADD, 0, 1, 0);
      #1 check("lu_stall", id_stall, 1);
      step();
      check("lu_bub_valid", ex_valid, 0);
      check("lu_bub_ctr", ALU_ctr, ALU_NOP);
      check("lu_bub_rw", ex_reg_write, 0);
      check("lu_stall_off", id_stall, 0);
      @(negedge clk) memwb_wen = 1'b1; memwb_dst = 8; memwb_data = 32'h1234;
      step();
      check("lu_fwd_a", ADin, 32'h1234);
      check("lu_b", BDin, 2);
      check("lu_valid", ex_valid, 1);

      @(negedge clk) instr(0, 5, 6, 32'h77, 1, 32'h100, ALU_SLL, 0, 1, 0);
      memwb_wen = 1'b0;
      step();
      check("sll_a", ADin, 1);
      check("sll_b", BDin, 32'h100);

      @(negedge clk) flush = 1'b1; ex_hold = 1'b1;
      step();
      check("flush_valid", ex_valid, 0);
      check("flush_ctr", ALU_ctr, ALU_NOP);
      @(negedge clk) flush = 1'b0; ex_hold = 1'b0;
      instr(1, 2, 3, 7, 5, 0, ALU_ADD, 0, 1, 0);
      step();
      @(negedge clk) ex_hold = 1'b1;
      instr(1, 2, 3, 32'h55, 32'h66, 0, ALU_SUB, 0, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("hold_a", ADin, 7);
         check("hold_ctr", ALU_ctr, ALU_ADD);
         check("hold_valid", ex_valid, 1);
         check("hold_stall", id_stall, 1);
      end

      @(negedge clk) ex_hold = 1'b0;
      instr(1, 2, 3, 32'h30, 32'h10, 0, ALU_SUB, 0, 1, 0);
      step();
      check("sub_a", ADin, 32'h30);
      check("sub_ctr", ALU_ctr, ALU_SUB);
      @(negedge clk) reset = 1'b1; ex_hold = 1'b1;
      #1 check("rst_hold_stall", id_stall, 0);
      step();
      check("rst2_valid", ex_valid, 0);
      check("rst2_a", ADin, 0);
      check("rst2_b", BDin, 0);
      check("rst2_ctr", ALU_ctr, ALU_NOP);
      check("rst2_stall", id_stall, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register directly upstream of the execute-stage ALU.
- Captures decoded operands and control each cycle, then drives the ALU's ADin/BDin/ALU_ctr/Carry_in.
- Applies EX/MEM and MEM/WB forwarding to the captured operands.
- Detects load-use hazards and inserts a bubble, stalling decode.

Parameters:
- n, 32, datapath width; matches ALU n.
- Ctr_size, 4, ALU control width; matches ALU Ctr_size.
- Rsel, 5, register index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs_data  in  n  register-file read data, rs.
- id_rt_data  in  n  register-file read data, rt.
- id_rs, id_rt, id_rd  in  Rsel  source and destination indices.
- id_imm  in  n  sign/zero-extended immediate; shamt in bits [10:6].
- id_alu_ctr  in  Ctr_size  ALU operation code.
- id_use_imm  in  1  B operand is the immediate.
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits.
- flush  in  1  squash the instruction entering EX (taken branch/jump).
- ex_hold  in  1  downstream freeze.
- exmem_wen  in  1  forwarding source write enable.
- exmem_dst  in  Rsel  forwarding source destination index.
- exmem_data  in  n  forwarding source data.
- memwb_wen  in  1  forwarding source write enable.
- memwb_dst  in  Rsel  forwarding source destination index.
- memwb_data  in  n  forwarding source data.
- ADin, BDin  out  n  ALU operands.
- ALU_ctr  out  Ctr_size  ALU operation.
- Carry_in  out  1  constant 0.
- ex_valid, ex_dst, ex_reg_write, ex_mem_read, ex_mem_write  out  registered to EX.
- ex_store_data  out  n  forwarded rt value, used for stores.
- id_stall  out  1  decode must hold its current instruction.

Behaviour:
- Reset (sync, at posedge with reset=1):
  - All registers clear: ex_valid=0, controls=0, indices=0, operands=0, ALU_ctr=`NOP.
  - id_stall=0 while reset is high.
- Hazard:
  - hz = ex_valid & ex_mem_read & id_valid & (ex_dst!=0) & (ex_dst==id_rs | ex_dst==id_rt).
  - Combinational.
- id_stall = hz | ex_hold.
- Register update per posedge, in priority order:
  1. reset.
  2. flush: load bubble (ex_valid=0, reg_write/mem_read/mem_write=0, ALU_ctr=`NOP). Flush overrides hold.
  3. ex_hold: keep all registers unchanged.
  4. hz: load bubble; decode holds.
  5. otherwise: capture all id_* fields. An id_valid=0 input loads as a bubble.
- Bubble rule: ex_valid=0 forces ex_reg_write/ex_mem_read/ex_mem_write=0.
- Forwarding (combinational on registered rs/rt data), per source s in {rs, rt}:
  - If idx!=0 & exmem_wen & exmem_dst==idx: use exmem_data.
  - Else if idx!=0 & memwb_wen & memwb_dst==idx: use memwb_data.
  - Else: registered value.
  - EX/MEM has priority over MEM/WB. Index 0 is never forwarded and reads the captured value.
- Operand routing:
  - Shift ops (ALU_ctr in `SLL/`SRL/`SRA): ADin = fwd_rt, BDin = imm (the ALU takes shamt from BDin[10:6]).
  - Otherwise: ADin = fwd_rs, BDin = use_imm ? imm : fwd_rt.
- ex_store_data = fwd_rt always.
- Carry_in = 0 always.
- Latency:
  - One cycle from ID capture to ADin/BDin valid.
  - Load-use costs exactly one bubble: on the next cycle the load sits in EX/MEM, and its result is forwarded from MEM/WB one cycle later.
- Reset mid-stall: pending hazard discarded; id_stall=0 while reset is high.

Decomposition:
- Shared defines header (existing): ALU control codes `ADD, `ADDU, `SUB, `SUBU, `SLT, `SLTU, `SLL, `SRL, `SRA, `OR, `AND, `XOR, `NOP.
  - Consumed identically by this block and the ALU.
  - Add a shared Rsel width define.
- One sub-module: fwd_mux.
  - Pure combinational idx/wen/dst/data priority select.
  - Instantiated twice (rs, rt).

Test Plan:
- Plain ADD: id_rs_data=7, id_rt_data=5, id_alu_ctr=`ADD, no forwarding -> next cycle ADin=7, BDin=5, ALU_ctr=`ADD, ex_valid=1, Carry_in=0.
- Double forward: captured rs=3, rt=3; exmem_wen=1, exmem_dst=3, exmem_data=0xAA; memwb_wen=1, memwb_dst=3, memwb_data=0xBB -> ADin=BDin=0xAA. With exmem_wen=0 -> 0xBB. Same stimulus with idx=0 -> captured values.
- Load-use: EX holds lw (mem_read=1) to $8; decode add uses $8.
  - Cycle 1: id_stall=1, next-cycle ex_valid=0, ALU_ctr=`NOP.
  - Cycle 2: add captured; memwb_dst=8, memwb_data=0x1234 -> ADin=0x1234.
- Shift: id_alu_ctr=`SLL, id_rt_data=1, id_imm=0x00000100 (shamt=4) -> ADin=1, BDin=0x100.
- Flush vs hold: flush=1 and ex_hold=1 same cycle -> ex_valid=0, ALU_ctr=`NOP. Then ex_hold=1 alone for 3 cycles -> outputs frozen, id_stall=1.
- Reset mid-operation: valid SUB in EX, assert reset one cycle -> ex_valid=0, ADin=BDin=0, ALU_ctr=`NOP, id_stall=0.
